periph_bus: RTL and testbench

Handshaked, parametrised successor of the CPU data-memory/GPIO peripheral. It sits between the core's memory stage and on-chip storage/IO. It decodes global-area RAM, stack RAM and a GPIO register window, and performs correct byte-lane sub-word stores and loads. Switches and buttons are synchronised and button edges are latched, with error reporting for illegal accesses. Keypad scanning and seven-segment drive stay in their own blocks, fed from this block's registers.

---
 rtl/periph_bus.sv | 216 +++++++++++++++++++++
 tb/tb_periph_bus.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus.sv
// Memory-stage peripheral bus: global/stack RAM with byte-lane access, GPIO register window,
// synchronised switches/buttons with a clear-on-read button edge latch. Three-cycle handshake.
module periph_bus #(
   parameter int          MEM_AW    = 10,
   parameter logic [15:0] GLOBAL_HI = 16'h8000,
   parameter logic [15:0] STACK_HI  = 16'h8003,
   parameter logic [15:0] GPIO_HI   = 16'hbf80,
   parameter int          N_LED     = 16,
   parameter int          N_SW      = 16,
   parameter int          N_PB      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [2:0]        dm_op,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [N_LED-1:0]  io_led,
   output logic [5:0]        seg_en,
   output logic [23:0]       seg_digits,
   input  logic [N_SW-1:0]   io_switch,
   input  logic [N_PB-1:0]   io_btn,
   input  logic [3:0]        keypad_data
);

   // SB/SH are store-only, BS/BZ/HS/HZ load-only, WD both ways; anything else is rejected.
   localparam logic [2:0] OP_WD = 3'd0, OP_SB = 3'd1, OP_SH = 3'd2, OP_BS = 3'd3,
                          OP_BZ = 3'd4, OP_HS = 3'd5, OP_HZ = 3'd6;
   localparam logic [15:0] OOB_MASK = 16'(32'hFFFF << (MEM_AW + 2));

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_RESP = 2'd2} state_t;

   function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] o);
      case (o)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
      logic signed [7:0] bs;
      bs = signed'(b);
      return sgn ? 32'(bs) : 32'(b);
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
      logic signed [15:0] hs;
      hs = signed'(h);
      return sgn ? 32'(hs) : 32'(h);
   endfunction

   state_t state_q, state_d;

   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  op_q;

   logic [31:0]      rdata_q, rdata_d;
   logic             err_q;
   logic [N_LED-1:0] led_q, led_d;
   logic [5:0]       seg_en_q, seg_en_d;
   logic [23:0]      digits_q, digits_d;
   logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
   logic [N_PB-1:0]  btn_s1_q, btn_s2_q, edge_q, edge_d;

   logic [31:0] gmem [2**MEM_AW];
   logic [31:0] smem [2**MEM_AW];

   logic              sz_half, sz_word, op_ok, ld_sgn;
   logic              is_g, is_s, is_io, is_ram;
   logic              ram_err, io_err, acc_err, acc_ok;
   logic              io_map, io_ro, io_wr, clr_edge, wr_g, wr_s;
   logic [MEM_AW-1:0] idx;
   logic [3:0]        be;
   logic [31:0]       wdata_rep, ram_word, ram_rd, io_rd;

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      case (state_q)
         S_IDLE:  if (req) state_d = S_ACC;
         S_ACC:   state_d = S_RESP;
         S_RESP:  begin
            ready   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && req) begin
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
         op_q    <= dm_op;
      end
   end

   // Access stage: decode and validate the latched request
   always_comb begin
      sz_half = 1'b0;
      sz_word = 1'b0;
      op_ok   = 1'b0;
      ld_sgn  = 1'b0;
      case (op_q)
         OP_WD: begin sz_word = 1'b1; op_ok = 1'b1;  end
         OP_SB: begin op_ok = we_q; end
         OP_SH: begin sz_half = 1'b1; op_ok = we_q; end
         OP_BS: begin op_ok = ~we_q; ld_sgn = 1'b1; end
         OP_BZ: begin op_ok = ~we_q; end
         OP_HS: begin sz_half = 1'b1; op_ok = ~we_q; ld_sgn = 1'b1; end
         OP_HZ: begin sz_half = 1'b1; op_ok = ~we_q; end
         default: ;
      endcase
   end

   assign is_g    = (addr_q[31:16] == GLOBAL_HI);
   assign is_s    = (addr_q[31:16] == STACK_HI);
   assign is_io   = (addr_q[31:16] == GPIO_HI);
   assign is_ram  = is_g | is_s;
   assign idx     = addr_q[MEM_AW+1:2];
   assign ram_err = ~op_ok | (sz_half & addr_q[0]) | (sz_word & (|addr_q[1:0]))
                  | (|(addr_q[15:0] & OOB_MASK));

   always_comb begin
      io_rd  = '0;
      io_ro  = 1'b0;
      io_map = 1'b1;
      case (addr_q[15:0])
         16'h0000: io_rd = 32'(led_q);
         16'h0004: begin io_rd = 32'(sw_s2_q);     io_ro = 1'b1; end
         16'h0008: begin io_rd = 32'(btn_s2_q);    io_ro = 1'b1; end
         16'h000C: io_rd = 32'(seg_en_q);
         16'h0010: io_rd = 32'(digits_q);
         16'h0014: begin io_rd = 32'(keypad_data); io_ro = 1'b1; end
         16'h0018: begin io_rd = 32'(edge_q);      io_ro = 1'b1; end
         default:  io_map = 1'b0;
      endcase
   end

   assign io_err  = (op_q != OP_WD) | ~io_map | (we_q & io_ro);
   assign acc_err = is_ram ? ram_err : (is_io ? io_err : 1'b1);
   assign acc_ok  = (state_q == S_ACC) & ~acc_err;

   assign be = sz_word ? 4'b1111 : (sz_half ? (addr_q[1] ? 4'b1100 : 4'b0011)
                                            : (4'b0001 << addr_q[1:0]));
   assign wdata_rep = sz_word ? wdata_q : (sz_half ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}});

   assign ram_word = is_s ? smem[idx] : gmem[idx];
   assign ram_rd   = sz_word ? ram_word
                   : (sz_half ? ext16(addr_q[1] ? ram_word[31:16] : ram_word[15:0], ld_sgn)
                              : ext8(sel_byte(ram_word, addr_q[1:0]), ld_sgn));
   assign rdata_d  = (acc_err | we_q) ? 32'h0 : (is_ram ? ram_rd : io_rd);

   assign wr_g     = acc_ok & is_g & we_q;
   assign wr_s     = acc_ok & is_s & we_q;
   assign io_wr    = acc_ok & is_io & we_q;
   assign clr_edge = acc_ok & is_io & ~we_q & (addr_q[15:0] == 16'h0018);

   assign led_d    = (io_wr && addr_q[15:0] == 16'h0000) ? wdata_q[N_LED-1:0] : led_q;
   assign seg_en_d = (io_wr && addr_q[15:0] == 16'h000C) ? wdata_q[5:0]       : seg_en_q;
   assign digits_d = (io_wr && addr_q[15:0] == 16'h0010) ? wdata_q[23:0]      : digits_q;
   // A rising edge on the same cycle as the clear must survive, so set is applied last
   assign edge_d   = (edge_q & ~{N_PB{clr_edge}}) | (btn_s1_q & ~btn_s2_q);

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_g && be[i]) gmem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         if (wr_s && be[i]) smem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         led_q    <= '0;
         seg_en_q <= 6'h3f;
         digits_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         led_q    <= led_d;
         seg_en_q <= seg_en_d;
         digits_q <= digits_d;
         sw_s1_q  <= io_switch;
         sw_s2_q  <= sw_s1_q;
         btn_s1_q <= io_btn;
         btn_s2_q <= btn_s1_q;
         edge_q   <= edge_d;
         if (state_q == S_ACC) begin
            rdata_q <= rdata_d;
            err_q   <= acc_err;
         end
      end
   end

   assign rdata      = rdata_q;
   assign err        = err_q;
   assign io_led     = led_q;
   assign seg_en     = seg_en_q;
   assign seg_digits = digits_q;

endmodule

// File: tb/tb_periph_bus.sv
// Randomised bench for periph_bus: transaction-level reference model plus directed scenarios.
module tb_periph_bus;
   localparam int MEM_AW = 10, N_LED = 16, N_SW = 16, N_PB = 5;
   localparam logic [2:0] WD = 3'd0, SB = 3'd1, SH = 3'd2, BS = 3'd3, BZ = 3'd4, HS = 3'd5, HZ = 3'd6;

   logic clk = 1'b0, rst = 1'b0, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [2:0] dm_op = '0;
   logic ready, err;
   logic [31:0] rdata;
   logic [N_LED-1:0] io_led;
   logic [5:0] seg_en;
   logic [23:0] seg_digits;
   logic [N_SW-1:0] io_switch = '0;
   logic [N_PB-1:0] io_btn = '0;
   logic [3:0] keypad_data = '0;

   always #5 clk = ~clk;

   periph_bus #(.MEM_AW(MEM_AW), .N_LED(N_LED), .N_SW(N_SW), .N_PB(N_PB)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .dm_op(dm_op),
      .ready(ready), .rdata(rdata), .err(err), .io_led(io_led), .seg_en(seg_en),
      .seg_digits(seg_digits), .io_switch(io_switch), .io_btn(io_btn), .keypad_data(keypad_data));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, expv);
      end
   endtask

   // Reference state
   logic [31:0] m_g [1024];
   logic [31:0] m_s [1024];
   logic [N_LED-1:0] m_led;
   logic [5:0]  m_seg_en;
   logic [23:0] m_dig;
   logic [N_SW-1:0] m_sw, cur_sw;
   logic [N_PB-1:0] m_btn, m_latch, cur_btn;
   logic [3:0]  m_key, cur_key;
   bit          exp_ready = 1'b0;
   logic        exp_err, got_err;
   logic [31:0] exp_rdata, got_rdata;

   task automatic reset_model();
      m_led = '0; m_seg_en = 6'h3f; m_dig = '0;
      m_sw = '0; m_btn = '0; m_latch = '0;
      cur_sw = '0; cur_btn = '0; cur_key = '0;
   endtask

   function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [2:0] op, input bit commit,
                                 output logic e, output logic [31:0] rd);
      int size, off, idx;
      bit sgn, legal, stk;
      logic [31:0] word, v;
      e = 1'b0; rd = '0; size = 0; sgn = 0; legal = 0;
      case (op)
         WD: begin size = 4; legal = 1; end
         SB: begin size = 1; legal = w; end
         SH: begin size = 2; legal = w; end
         BS: begin size = 1; legal = !w; sgn = 1; end
         BZ: begin size = 1; legal = !w; end
         HS: begin size = 2; legal = !w; sgn = 1; end
         HZ: begin size = 2; legal = !w; end
         default: legal = 0;
      endcase
      if (a[31:16] == 16'h8000 || a[31:16] == 16'h8003) begin
         stk = (a[31:16] == 16'h8003);
         off = int'(a[1:0]);
         if (!legal || (off % size) != 0 || int'(a[15:0]) >= (4 << MEM_AW)) e = 1'b1;
         else begin
            idx  = int'(a[15:0]) / 4;
            word = stk ? m_s[idx] : m_g[idx];
            if (w) begin
               for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
               if (commit) begin
                  if (stk) m_s[idx] = word; else m_g[idx] = word;
               end
            end else begin
               v = word >> (8*off);
               if (size == 1)      rd = sgn ? {{24{v[7]}}, v[7:0]}   : {24'h0, v[7:0]};
               else if (size == 2) rd = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
               else                rd = v;
            end
         end
      end else if (a[31:16] == 16'hbf80) begin
         if (op != WD) e = 1'b1;
         else case (a[15:0])
            16'h0000: if (w) begin if (commit) m_led = wd[N_LED-1:0]; end else rd = 32'(m_led);
            16'h0004: if (w) e = 1'b1; else rd = 32'(m_sw);
            16'h0008: if (w) e = 1'b1; else rd = 32'(m_btn);
            16'h000C: if (w) begin if (commit) m_seg_en = wd[5:0]; end else rd = 32'(m_seg_en);
            16'h0010: if (w) begin if (commit) m_dig = wd[23:0]; end else rd = 32'(m_dig);
            16'h0014: if (w) e = 1'b1; else rd = 32'(m_key);
            16'h0018: if (w) e = 1'b1; else begin rd = 32'(m_latch); if (commit) m_latch = '0; end
            default:  e = 1'b1;
         endcase
      end else e = 1'b1;
      if (e || w) rd = '0;
   endfunction

   // One access; pin changes presented with the request reach the synchronised view after it.
   task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op);
      logic e;
      logic [31:0] rd;
      @(negedge clk);
      m_key = cur_key;
      model(w, a, wd, op, 1'b0, e, rd);
      exp_err = e; exp_rdata = rd;
      req = 1'b1; we = w; addr = a; wdata = wd; dm_op = op;
      io_switch = cur_sw; io_btn = cur_btn; keypad_data = cur_key;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_ready = 1'b1;
      model(w, a, wd, op, 1'b1, e, rd);
      m_latch = m_latch | (cur_btn & ~m_btn);
      m_btn = cur_btn;
      m_sw  = cur_sw;
      got_rdata = rdata; got_err = err;
      @(negedge clk);
      req = 1'b0;
      @(posedge clk); #1;
      exp_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("ready", 32'(ready), 32'(exp_ready));
         if (exp_ready) begin
            chk("rdata", rdata, exp_rdata);
            chk("err", 32'(err), 32'(exp_err));
         end
         chk("io_led", 32'(io_led), 32'(m_led));
         chk("seg_en", 32'(seg_en), 32'(m_seg_en));
         chk("seg_digits", 32'(seg_digits), 32'(m_dig));
      end
   end

   initial begin
      int r, k, idx;
      logic w;
      logic [2:0] op;
      logic [31:0] a, wd;
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_led", 32'(io_led), 32'h0);
      chk("rst_seg_en", 32'(seg_en), 32'h3f);
      chk("rst_digits", 32'(seg_digits), 32'h0);
      @(posedge clk); #2 rst = 1'b1;
      repeat (2) @(posedge clk);

      for (int j = 0; j < 32; j++) begin
         idx = (j < 16) ? j : 1008 + j - 16;
         acc(1'b1, {16'h8000, 16'(idx*4)}, $urandom, WD);
         acc(1'b1, {16'h8003, 16'(idx*4)}, $urandom, WD);
      end

      acc(1'b1, 32'h80000010, 32'h11223344, WD);
      acc(1'b0, 32'h80000012, 32'h0, BZ); chk("bz_global", got_rdata, 32'h00000022);
      acc(1'b0, 32'h80000012, 32'h0, HS); chk("hs_global", got_rdata, 32'h00001122);
      acc(1'b1, 32'h80030004, 32'h0, WD);
      acc(1'b1, 32'h80030005, 32'h000000AB, SB);
      acc(1'b0, 32'h80030004, 32'h0, WD); chk("sb_stack_word", got_rdata, 32'h0000AB00);
      acc(1'b0, 32'h80030005, 32'h0, BS); chk("bs_stack", got_rdata, 32'hFFFFFFAB);
      acc(1'b1, 32'h80000000, 32'h0BADF00D, WD);
      acc(1'b1, 32'h80000001, 32'h0000FFFF, SH);
      chk("sh_misalign_err", 32'(got_err), 32'h1); chk("sh_misalign_rdata", got_rdata, 32'h0);
      acc(1'b0, 32'h80000000, 32'h0, WD); chk("sh_misalign_nochange", got_rdata, 32'h0BADF00D);
      acc(1'b0, 32'h80001000, 32'h0, WD); chk("oob_err", 32'(got_err), 32'h1);
      acc(1'b1, 32'hbf800004, 32'h5, WD);
      chk("ro_write_err", 32'(got_err), 32'h1); chk("ro_write_rdata", got_rdata, 32'h0);
      acc(1'b1, 32'hbf800000, 32'h0000A5A5, WD); chk("led_out", 32'(io_led), 32'h0000A5A5);
      acc(1'b0, 32'hbf800000, 32'h0, WD);        chk("led_readback", got_rdata, 32'h0000A5A5);
      acc(1'b1, 32'hbf80000C, 32'h15, WD);       chk("seg_en_write", 32'(seg_en), 32'h15);

      cur_btn = 5'h04; acc(1'b0, 32'hbf800000, 32'h0, WD);
      cur_btn = 5'h00; acc(1'b0, 32'hbf800000, 32'h0, WD);
      acc(1'b0, 32'hbf800018, 32'h0, WD); chk("btn_edge", got_rdata, 32'h4);
      acc(1'b0, 32'hbf800018, 32'h0, WD); chk("btn_clear", got_rdata, 32'h0);
      cur_btn = 5'h04; acc(1'b0, 32'hbf800018, 32'h0, WD); chk("btn_coll_first", got_rdata, 32'h0);
      cur_btn = 5'h00; acc(1'b0, 32'hbf800018, 32'h0, WD); chk("btn_coll_kept", got_rdata, 32'h4);

      // Reset while the response is being presented
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h80000010; dm_op = WD;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("resp_ready_before_rst", 32'(ready), 32'h1);
      rst = 1'b0; req = 1'b0;
      io_btn = '0; io_switch = '0; keypad_data = '0;
      reset_model();
      #1 chk("resp_ready_cancelled", 32'(ready), 32'h0);
      chk("resp_rst_seg_en", 32'(seg_en), 32'h3f);
      @(posedge clk); #2 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Reset while a store sits in the access cycle
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h80000000; wdata = 32'hDEADBEEF; dm_op = WD;
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("acc_rst_no_ready", 32'(ready), 32'h0);
      @(posedge clk); #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      acc(1'b0, 32'h80000000, 32'h0, WD); chk("acc_rst_mem_kept", got_rdata, 32'h0BADF00D);

      for (int t = 0; t < 300; t++) begin
         r  = $urandom_range(0, 9);
         w  = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (r < 7) begin
            k   = $urandom_range(0, 31);
            idx = (k < 16) ? k : 1008 + k - 16;
            a   = {(r < 4) ? 16'h8000 : 16'h8003, 16'(idx*4 + $urandom_range(0, 3))};
         end else if (r < 9) begin
            a = {16'hbf80, 16'($urandom_range(0, 8) * 4 + (($urandom_range(0, 7) == 0) ? 1 : 0))};
            if ($urandom_range(0, 3) != 0) op = WD;
         end else begin
            a = ($urandom_range(0, 1) == 1) ? $urandom : {16'h8000, 16'($urandom_range(1, 15) << 12)};
         end
         if ($urandom_range(0, 3) == 0) cur_btn = N_PB'($urandom);
         if ($urandom_range(0, 3) == 0) cur_sw = N_SW'($urandom);
         cur_key = 4'($urandom);
         acc(w, a, wd, op);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
